// File: rtl/gpr_writeback_queue.sv
// Merges pipeline writeback and buffered MDU results onto the single GPR write port; optional trace under GPR_WBQ_TRACE_EN.
// Latency: pipeline writes reach the port in 0 cycles; MDU results reach it no earlier than the cycle after enqueue.
// Backpressure: mduReady = !full and ignores a same-cycle pop; the pipeline path is never stalled.
module gpr_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbValid,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    input  logic [31:0] wbPc,
    input  logic        mduValid,
    input  logic [4:0]  mduAddr,
    input  logic [31:0] mduData,
    input  logic [31:0] mduPc,
    output logic        mduReady,
    input  logic [4:0]  readAddr1,
    input  logic [4:0]  readAddr2,
    output logic        pending1,
    output logic        pending2,
    output logic        regWrite,
    output logic [4:0]  writeAddr,
    output logic [31:0] writeData,
    output logic [31:0] pc
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] ent_vld;
    logic [4:0]       ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [31:0]      ent_pc   [DEPTH];
    logic [AW-1:0]    head, tail;
    logic [AW:0]      count;

    logic wb_kill, mdu_kill, enq, pop, in_live;

    assign mduReady = (count != FULL_CNT);
    assign wb_kill  = wbValid && (wbAddr != 5'd0);
    // An MDU result arriving alongside a pipeline write to the same register is the older value.
    assign mdu_kill = wb_kill && (mduAddr == wbAddr);
    assign in_live  = mduValid && mduReady && (mduAddr != 5'd0) && !mdu_kill;
    assign enq      = in_live;
    assign pop      = !wbValid && (count != '0);

    always_comb begin
        regWrite  = 1'b0;
        writeAddr = 5'd0;
        writeData = 32'd0;
        pc        = 32'd0;
        if (wbValid) begin
            regWrite  = (wbAddr != 5'd0);
            writeAddr = wbAddr;
            writeData = wbData;
            pc        = wbPc;
        end else if (count != '0) begin
            regWrite  = ent_vld[head];
            writeAddr = ent_addr[head];
            writeData = ent_data[head];
            pc        = ent_pc[head];
        end
    end

    always_comb begin
        pending1 = in_live && (mduAddr == readAddr1);
        pending2 = in_live && (mduAddr == readAddr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == readAddr1)) pending1 = 1'b1;
            if (ent_vld[i] && (ent_addr[i] == readAddr2)) pending2 = 1'b1;
        end
        if (readAddr1 == 5'd0) pending1 = 1'b0;
        if (readAddr2 == 5'd0) pending2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_vld <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_kill && (ent_addr[i] == wbAddr)) ent_vld[i] <= 1'b0;
            end
            // Free slots always read as invalid so pending only sees live entries.
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (enq) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            ent_addr[tail] <= mduAddr;
            ent_data[tail] <= mduData;
            ent_pc[tail]   <= mduPc;
        end
    end

`ifdef GPR_WBQ_TRACE_EN
    always @(posedge clk) begin
        if (!reset && regWrite) $display("@%h: $%d <= %h", pc, writeAddr, writeData);
    end
`else
`endif

endmodule

// File: tb/tb_gpr_writeback_queue.sv
// Randomized and directed bench for gpr_writeback_queue, checked against a queue-based model.
module tb_gpr_writeback_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbValid;
    logic [4:0]  wbAddr;
    logic [31:0] wbData, wbPc;
    logic        mduValid;
    logic [4:0]  mduAddr;
    logic [31:0] mduData, mduPc;
    logic        mduReady;
    logic [4:0]  readAddr1, readAddr2;
    logic        pending1, pending2;
    logic        regWrite;
    logic [4:0]  writeAddr;
    logic [31:0] writeData, pc;

    gpr_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData), .wbPc(wbPc),
        .mduValid(mduValid), .mduAddr(mduAddr), .mduData(mduData), .mduPc(mduPc),
        .mduReady(mduReady), .readAddr1(readAddr1), .readAddr2(readAddr2),
        .pending1(pending1), .pending2(pending2), .regWrite(regWrite),
        .writeAddr(writeAddr), .writeData(writeData), .pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [4:0]  a;
        bit [31:0] d;
        bit [31:0] p;
    } ent_t;
    ent_t q[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit wv, input bit [4:0] wa, input bit [31:0] wd,
                         input bit mv, input bit [4:0] ma, input bit [31:0] md,
                         input bit [4:0] r1, input bit [4:0] r2);
        reset = rst; wbValid = wv; wbAddr = wa; wbData = wd; wbPc = 32'h1000 + {27'd0, wa};
        mduValid = mv; mduAddr = ma; mduData = md; mduPc = 32'h3000 + {27'd0, ma};
        readAddr1 = r1; readAddr2 = r2;
    endtask

    function automatic bit incoming_live();
        bit killed;
        killed = wbValid && wbAddr != 0 && wbAddr == mduAddr;
        return mduValid && (q.size() < DEPTH) && mduAddr != 0 && !killed;
    endfunction

    function automatic bit model_pending(input bit [4:0] ra);
        if (ra == 0) return 0;
        if (incoming_live() && mduAddr == ra) return 1;
        foreach (q[i]) if (q[i].v && q[i].a == ra) return 1;
        return 0;
    endfunction

    // Compare against the model at the negative edge, after inputs have settled.
    task automatic half();
        bit        e_rw;
        bit [4:0]  e_wa;
        bit [31:0] e_wd, e_pc;
        @(negedge clk);
        e_rw = 0; e_wa = 0; e_wd = 0; e_pc = 0;
        if (wbValid) begin
            e_rw = (wbAddr != 0); e_wa = wbAddr; e_wd = wbData; e_pc = wbPc;
        end else if (q.size() != 0) begin
            e_rw = q[0].v; e_wa = q[0].a; e_wd = q[0].d; e_pc = q[0].p;
        end
        chk("mduReady", {31'd0, mduReady}, {31'd0, q.size() < DEPTH});
        chk("pending1", {31'd0, pending1}, {31'd0, model_pending(readAddr1)});
        chk("pending2", {31'd0, pending2}, {31'd0, model_pending(readAddr2)});
        chk("regWrite", {31'd0, regWrite}, {31'd0, e_rw});
        chk("writeAddr", {27'd0, writeAddr}, {27'd0, e_wa});
        chk("writeData", writeData, e_wd);
        chk("pc", pc, e_pc);
    endtask

    // Advance the model across the clock edge using the inputs held this cycle.
    task automatic fin();
        bit en, popf;
        ent_t e;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            en   = incoming_live();
            popf = !wbValid && q.size() != 0;
            if (wbValid && wbAddr != 0)
                foreach (q[i]) if (q[i].a == wbAddr) q[i].v = 0;
            if (popf) void'(q.pop_front());
            if (en) begin
                e.v = 1; e.a = mduAddr; e.d = mduData; e.p = mduPc;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; fin();
        // idle after reset
        idle(); half();
        chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("rst_mduReady", {31'd0, mduReady}, 32'd1);
        chk("rst_pend1", {31'd0, pending1}, 32'd0);
        chk("rst_pend2", {31'd0, pending2}, 32'd0);
        fin();

        // single MDU result reaches the port the following cycle
        drive(0, 0, 0, 0, 1, 8, 32'h12345678, 0, 0);
        mduPc = 32'h3000;
        half(); fin();
        idle(); half();
        chk("mdu_rw", {31'd0, regWrite}, 32'd1);
        chk("mdu_addr", {27'd0, writeAddr}, 32'd8);
        chk("mdu_data", writeData, 32'h12345678);
        chk("mdu_pc", pc, 32'h3000);
        fin();

        // fill under sustained wb, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 32'hBEEF, 1, 5'(10 + i), 32'(100 + i), 0, 0);
            half(); fin();
        end
        drive(0, 1, 1, 32'hBEEF, 1, 14, 32'd104, 0, 0);
        half(); chk("full_ready", {31'd0, mduReady}, 32'd0); fin();
        drive(0, 0, 0, 0, 1, 14, 32'd104, 0, 0);
        half(); chk("drain0", {27'd0, writeAddr}, 32'd10);
        chk("full_pop_ready", {31'd0, mduReady}, 32'd0); fin();
        drive(0, 0, 0, 0, 1, 14, 32'd104, 0, 0);
        half(); chk("drain1", {27'd0, writeAddr}, 32'd11);
        chk("ready_again", {31'd0, mduReady}, 32'd1); fin();
        for (int i = 0; i < 3; i++) begin
            idle(); half();
            chk("drain_n", {27'd0, writeAddr}, 32'(12 + i));
            chk("drain_data", writeData, 32'(102 + i));
            fin();
        end
        idle(); half(); chk("drained_rw", {31'd0, regWrite}, 32'd0); fin();

        // kill of a queued entry by a younger wb write
        drive(0, 0, 0, 0, 1, 9, 32'h5555, 0, 0); half(); fin();
        drive(0, 1, 9, 32'hAAAA, 0, 0, 0, 9, 0);
        half();
        chk("kill_wbdata", writeData, 32'hAAAA);
        chk("kill_pend_before", {31'd0, pending1}, 32'd1);
        fin();
        drive(0, 0, 0, 0, 0, 0, 0, 9, 0);
        half();
        chk("killed_pop_rw", {31'd0, regWrite}, 32'd0);
        chk("killed_pend", {31'd0, pending1}, 32'd0);
        fin();

        // pending tracking
        drive(0, 1, 2, 32'h22, 1, 5, 32'h55, 0, 0); half(); fin();
        drive(0, 1, 2, 32'h22, 0, 0, 0, 5, 0);
        half();
        chk("pend1_set", {31'd0, pending1}, 32'd1);
        chk("pend2_clr", {31'd0, pending2}, 32'd0);
        fin();
        drive(0, 0, 0, 0, 0, 0, 0, 5, 0); half(); fin();
        drive(0, 0, 0, 0, 0, 0, 0, 5, 0);
        half(); chk("pend1_drained", {31'd0, pending1}, 32'd0); fin();

        // register zero on both paths
        drive(0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
        half(); chk("mdu0_ready", {31'd0, mduReady}, 32'd1); fin();
        idle(); half(); chk("mdu0_rw", {31'd0, regWrite}, 32'd0); fin();
        drive(0, 1, 0, 32'hF00D, 0, 0, 0, 0, 0);
        half(); chk("wb0_rw", {31'd0, regWrite}, 32'd0); fin();

        // reset with a backlog
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 3, 32'h33, 1, 5'(20 + i), 32'(i), 0, 0);
            half(); fin();
        end
        drive(1, 0, 0, 0, 1, 23, 32'h77, 0, 0); half(); fin();
        idle(); half();
        chk("post_rst_rw", {31'd0, regWrite}, 32'd0);
        chk("post_rst_ready", {31'd0, mduReady}, 32'd1);
        fin();
        idle(); half(); chk("post_rst_rw2", {31'd0, regWrite}, 32'd0); fin();

        // randomized traffic with small address range to force collisions
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            half(); fin();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gpr_writeback_queue.md
# gpr_writeback_queue

Write-side front end for the general-purpose register file. It merges two result producers onto the register file's single write port: the in-order pipeline writeback, which is never stalled, and the multiply/divide unit (MDU), whose results are buffered in a small FIFO. It kills buffered results that a younger pipeline write has superseded. It also reports per-read-port pending hazards so decode can stall.

## Interface
Parameters:
- DEPTH, 4, MDU result FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- wbValid  input  1  pipeline writeback request; always accepted.
- wbAddr  input  5  pipeline destination register.
- wbData  input  32  pipeline write data.
- wbPc  input  32  PC of the writing instruction.
- mduValid  input  1  MDU result valid.
- mduAddr  input  5  MDU destination register.
- mduData  input  32  MDU result.
- mduPc  input  32  PC of the MDU instruction.
- mduReady  output  1  FIFO can accept; equals !full.
- readAddr1  input  5  decode read port 1 address.
- readAddr2  input  5  decode read port 2 address.
- pending1  output  1  readAddr1 has an outstanding MDU write.
- pending2  output  1  readAddr2 has an outstanding MDU write.
- regWrite  output  1  register file write enable.
- writeAddr  output  5  register file write address.
- writeData  output  32  register file write data.
- pc  output  32  PC forwarded to the register file.

## Operation
- FIFO state: entries {valid, addr, data, pc}, plus head pointer, tail pointer and count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Enqueue happens when mduValid && mduReady && mduAddr != 0 and the entry is not killed. A result with mduAddr == 0 is accepted (handshake completes) but discarded.
- Output mux, combinational:
  - If wbValid: regWrite = (wbAddr != 0), and writeAddr, writeData and pc come from the wb* inputs. The FIFO does not pop.
  - Else, if count != 0: pop the head. regWrite = head.valid, and the outputs come from the head entry. A killed head pops with regWrite = 0.
  - Else: regWrite = 0, writeAddr = 0, writeData = 0, pc = 0.
- Kill rule: when wbValid && wbAddr != 0, clear the valid bit of every stored entry whose addr == wbAddr. An incoming MDU result to the same address in that cycle is older and is discarded.
- pending1 = readAddr1 != 0 && (any stored valid entry with addr == readAddr1, or an accepted incoming MDU result targeting readAddr1 that survives the kill rule). pending2 is defined the same way.
- Simultaneous enqueue and pop in one cycle: count is unchanged and both pointers advance.
- mduReady does not account for a same-cycle pop. When full, the FIFO rejects the incoming result even if it pops that cycle.

## Timing
- All outputs are combinational from the inputs and the FIFO state. The register file captures the write at the next clk edge.
- Pipeline write path latency: 0 cycles to the port.
- MDU path: enqueue at edge N. The earliest write on the port is cycle N+1, if wbValid is low that cycle.
- Reset: count, head and tail go to 0 and all valid bits clear, at the next edge. Any in-flight MDU result presented during the reset cycle is dropped.
- Output values while the FIFO is empty and wbValid is low: mduReady = 1, pending1 = 0, pending2 = 0, regWrite = 0, writeAddr = 0, writeData = 0, pc = 0.
- A DEPTH-entry backlog drains in DEPTH cycles in which wbValid is low. Sustained wbValid starves the FIFO; this is acceptable because decode stalls on pending1 and pending2.

## Configuration
- GPR_WBQ_TRACE_EN:
  - Defined: at each clk edge where !reset && regWrite, print "@%h: $%d <= %h" with pc, writeAddr and writeData.
  - Undefined: no simulation output; the RTL is otherwise identical.

## Test plan
- Reset, then idle: regWrite = 0, mduReady = 1, pending1 = 0, pending2 = 0.
- MDU result ($8, 0x12345678, pc 0x3000) with wbValid low → enqueued at edge 1. In the next cycle regWrite = 1, writeAddr = 8, writeData = 0x12345678, pc = 0x3000.
- Four MDU results while wbValid is held high → mduReady falls to 0 after the fourth. A fifth result is held until wbValid drops. The entries then drain in FIFO order, one per cycle.
- Queue holds $9. A wb write to $9 (0xAAAA) → the queue entry is killed. When that entry later pops, regWrite = 0 and $9 keeps 0xAAAA.
- With $5 queued and readAddr1 = 5, readAddr2 = 0 → pending1 = 1, pending2 = 0. After $5 drains, pending1 = 0.
- MDU result to $0, and separately a wb write to $0 → the MDU result is accepted but never enqueued, and regWrite stays 0 in both cases. Asserting reset with 3 entries queued → count = 0 and no further writes.
